// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Package : switch_pkg
// Brief   : Shared MAC types, helpers and MAC-table FSM encoding for the switch core.
// Rev     : 1.0  initial release
// ============================================================================
package switch_pkg;

    localparam int MAC_WIDTH = 48;

    typedef logic [MAC_WIDTH-1:0] mac_address_t;

    // I/G bit: least significant bit of the first transmitted octet
    localparam mac_address_t c_GROUP_BIT = 48'h01_00_00_00_00_00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        LEARN   = 2'd2,
        RESPOND = 2'd3
    } mac_table_state_t;

    function automatic logic is_multicast(input mac_address_t mac);
        return |(mac & c_GROUP_BIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_age_timer.sv
`default_nettype none
// ============================================================================
// Module  : mac_age_timer
// Brief   : Free-running counter emitting a one-cycle tick every AGE_TICK_CYCLES.
// Rev     : 1.0  initial release
// ============================================================================
module mac_age_timer #(
    parameter int AGE_TICK_CYCLES = 50000000
) (
    input  logic clock,
    input  logic reset,
    output logic o_tick
);

    localparam int c_WIDTH = ($clog2(AGE_TICK_CYCLES) < 1) ? 1 : $clog2(AGE_TICK_CYCLES);
    localparam logic [c_WIDTH-1:0] c_LAST_COUNT = c_WIDTH'(AGE_TICK_CYCLES - 1);

    logic [c_WIDTH-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == c_LAST_COUNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == c_LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/mac_learning_table.sv
`default_nettype none
// ============================================================================
// Module  : mac_learning_table
// Brief   : Sequential-scan MAC learning/forwarding table with aging and flush.
// Rev     : 1.0  initial release
// ============================================================================
module mac_learning_table
    import switch_pkg::*;
#(
    parameter int NUMBER_OF_PORTS = 2,
    parameter int TABLE_ENTRIES   = 16,
    parameter int AGE_TICK_CYCLES = 50000000,
    parameter int AGE_LIMIT       = 300,
    localparam int PORT_WIDTH     = ($clog2(NUMBER_OF_PORTS) < 1) ? 1 : $clog2(NUMBER_OF_PORTS),
    localparam int COUNT_WIDTH    = $clog2(TABLE_ENTRIES + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       request_valid,
    output logic                       request_ready,
    input  logic [47:0]                request_source_mac,
    input  logic [47:0]                request_destination_mac,
    input  logic [PORT_WIDTH-1:0]      request_source_port,
    output logic                       response_valid,
    input  logic                       response_ready,
    output logic [NUMBER_OF_PORTS-1:0] response_port_mask,
    output logic                       response_hit,
    input  logic                       flush,
    output logic [COUNT_WIDTH-1:0]     entry_count
);

    localparam int c_INDEX_WIDTH = $clog2(TABLE_ENTRIES);
    localparam int c_AGE_WIDTH   = $clog2(AGE_LIMIT + 1);
    localparam logic [c_INDEX_WIDTH-1:0] c_LAST_INDEX = c_INDEX_WIDTH'(TABLE_ENTRIES - 1);
    localparam logic [c_AGE_WIDTH-1:0]   c_AGE_LIMIT  = c_AGE_WIDTH'(AGE_LIMIT);

    typedef struct packed {
        logic                   valid;
        mac_address_t           mac;
        logic [PORT_WIDTH-1:0]  port;
        logic [c_AGE_WIDTH-1:0] age;
    } cam_entry_t;

    cam_entry_t       r_table [TABLE_ENTRIES];
    mac_table_state_t r_state;
    mac_table_state_t w_next_state;

    logic                       r_ready_enable;
    logic                       r_flush_pending;
    logic                       r_age_pending;
    mac_address_t               r_src_mac;
    mac_address_t               r_dst_mac;
    logic [PORT_WIDTH-1:0]      r_src_port;
    logic [c_INDEX_WIDTH-1:0]   r_scan_index;
    logic                       r_dst_hit;
    logic [PORT_WIDTH-1:0]      r_dst_port;
    logic                       r_src_hit;
    logic [c_INDEX_WIDTH-1:0]   r_src_index;
    logic                       r_free_found;
    logic [c_INDEX_WIDTH-1:0]   r_free_index;
    logic                       r_oldest_found;
    logic [c_INDEX_WIDTH-1:0]   r_oldest_index;
    logic [c_AGE_WIDTH-1:0]     r_oldest_age;
    logic [NUMBER_OF_PORTS-1:0] r_resp_mask;
    logic                       r_resp_hit;

    logic                       w_tick;
    logic                       w_accept;
    logic                       w_service_flush;
    logic                       w_service_age;
    logic                       w_learn_we;
    logic [c_INDEX_WIDTH-1:0]   w_learn_index;
    logic [NUMBER_OF_PORTS-1:0] w_flood_mask;
    logic [NUMBER_OF_PORTS-1:0] w_dst_onehot;
    logic [COUNT_WIDTH-1:0]     w_count;
    cam_entry_t                 w_entry;

    mac_age_timer #(
        .AGE_TICK_CYCLES(AGE_TICK_CYCLES)
    ) u_age_timer (
        .clock  (clock),
        .reset  (reset),
        .o_tick (w_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush outranks aging, aging outranks new lookups while idle
    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_service_flush = 1'b0;
        w_service_age   = 1'b0;
        request_ready   = 1'b0;
        response_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                request_ready = r_ready_enable && !r_flush_pending && !r_age_pending;
                if (r_flush_pending) begin
                    w_service_flush = 1'b1;
                end else if (r_age_pending) begin
                    w_service_age = 1'b1;
                end else if (request_valid && r_ready_enable) begin
                    w_accept     = 1'b1;
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (r_scan_index == c_LAST_INDEX) begin
                    w_next_state = LEARN;
                end
            end
            LEARN: begin
                w_next_state = RESPOND;
            end
            RESPOND: begin
                response_valid = 1'b1;
                if (response_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_entry       = r_table[r_scan_index];
    assign w_learn_we    = (r_state == LEARN) && !is_multicast(r_src_mac);
    assign w_learn_index = r_src_hit ? r_src_index : (r_free_found ? r_free_index : r_oldest_index);
    assign w_flood_mask  = ~({{(NUMBER_OF_PORTS-1){1'b0}}, 1'b1} << r_src_port);
    assign w_dst_onehot  = {{(NUMBER_OF_PORTS-1){1'b0}}, 1'b1} << r_dst_port;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready_enable  <= 1'b0;
            r_flush_pending <= 1'b0;
            r_age_pending   <= 1'b0;
            r_src_mac       <= '0;
            r_dst_mac       <= '0;
            r_src_port      <= '0;
            r_scan_index    <= '0;
            r_dst_hit       <= 1'b0;
            r_dst_port      <= '0;
            r_src_hit       <= 1'b0;
            r_src_index     <= '0;
            r_free_found    <= 1'b0;
            r_free_index    <= '0;
            r_oldest_found  <= 1'b0;
            r_oldest_index  <= '0;
            r_oldest_age    <= '0;
            r_resp_mask     <= '0;
            r_resp_hit      <= 1'b0;
            for (int i = 0; i < TABLE_ENTRIES; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_ready_enable  <= 1'b1;
            r_flush_pending <= flush | (r_flush_pending & ~w_service_flush);
            r_age_pending   <= w_tick | (r_age_pending & ~w_service_age);

            if (w_accept) begin
                r_src_mac      <= request_source_mac;
                r_dst_mac      <= request_destination_mac;
                r_src_port     <= request_source_port;
                r_scan_index   <= '0;
                r_dst_hit      <= 1'b0;
                r_dst_port     <= '0;
                r_src_hit      <= 1'b0;
                r_src_index    <= '0;
                r_free_found   <= 1'b0;
                r_free_index   <= '0;
                r_oldest_found <= 1'b0;
                r_oldest_index <= '0;
                r_oldest_age   <= '0;
            end

            if (r_state == SCAN) begin
                r_scan_index <= r_scan_index + 1'b1;
                if (w_entry.valid) begin
                    if (w_entry.mac == r_dst_mac) begin
                        r_dst_hit  <= 1'b1;
                        r_dst_port <= w_entry.port;
                    end
                    if (w_entry.mac == r_src_mac) begin
                        r_src_hit   <= 1'b1;
                        r_src_index <= r_scan_index;
                    end
                    // Strict compare keeps the lowest index on equal ages
                    if (!r_oldest_found || (w_entry.age > r_oldest_age)) begin
                        r_oldest_found <= 1'b1;
                        r_oldest_index <= r_scan_index;
                        r_oldest_age   <= w_entry.age;
                    end
                end else if (!r_free_found) begin
                    r_free_found <= 1'b1;
                    r_free_index <= r_scan_index;
                end
            end

            if (r_state == LEARN) begin
                if (is_multicast(r_dst_mac) || !r_dst_hit) begin
                    r_resp_hit  <= 1'b0;
                    r_resp_mask <= w_flood_mask;
                end else begin
                    r_resp_hit  <= 1'b1;
                    r_resp_mask <= (r_dst_port == r_src_port) ? '0 : w_dst_onehot;
                end
            end

            for (int i = 0; i < TABLE_ENTRIES; i++) begin
                if (w_service_flush) begin
                    r_table[i].valid <= 1'b0;
                end else if (w_service_age && r_table[i].valid) begin
                    r_table[i].age <= r_table[i].age + 1'b1;
                    if ((r_table[i].age + 1'b1) == c_AGE_LIMIT) begin
                        r_table[i].valid <= 1'b0;
                    end
                end else if (w_learn_we && (w_learn_index == c_INDEX_WIDTH'(i))) begin
                    r_table[i].valid <= 1'b1;
                    r_table[i].mac   <= r_src_mac;
                    r_table[i].port  <= r_src_port;
                    r_table[i].age   <= '0;
                end
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < TABLE_ENTRIES; i++) begin
            w_count = w_count + COUNT_WIDTH'(r_table[i].valid);
        end
    end

    assign entry_count        = w_count;
    assign response_port_mask = r_resp_mask;
    assign response_hit       = r_resp_hit;

endmodule
`default_nettype wire

// File: tb/tb_mac_learning_table.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_learning_table
// Brief   : Directed self-checking bench; three table configurations share one clock.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mac_learning_table;

    localparam int ND = 3;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] M1    = 48'hAA00_0000_0001;
    localparam logic [47:0] M2    = 48'hAA00_0000_0002;
    localparam logic [47:0] M3    = 48'hAA00_0000_0003;
    localparam logic [47:0] M4    = 48'hAA00_0000_0004;
    localparam logic [47:0] M5    = 48'hAA00_0000_0005;
    localparam logic [47:0] MUNK  = 48'hAA00_0000_00FF;
    localparam logic [47:0] MMC   = 48'h01AA_0000_0099;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid  [ND];
    logic        req_ready  [ND];
    logic [47:0] src        [ND];
    logic [47:0] dst        [ND];
    logic [1:0]  sport      [ND];
    logic        resp_valid [ND];
    logic        resp_ready [ND];
    logic [3:0]  mask       [ND];
    logic        hit        [ND];
    logic        flush      [ND];
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic [2:0]  cnt_c;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    mac_learning_table #(.NUMBER_OF_PORTS(4), .TABLE_ENTRIES(16), .AGE_TICK_CYCLES(100000), .AGE_LIMIT(300)) dut_a (
        .clock(clock), .reset(reset), .request_valid(req_valid[0]), .request_ready(req_ready[0]),
        .request_source_mac(src[0]), .request_destination_mac(dst[0]), .request_source_port(sport[0]),
        .response_valid(resp_valid[0]), .response_ready(resp_ready[0]), .response_port_mask(mask[0]),
        .response_hit(hit[0]), .flush(flush[0]), .entry_count(cnt_a));

    mac_learning_table #(.NUMBER_OF_PORTS(4), .TABLE_ENTRIES(4), .AGE_TICK_CYCLES(10), .AGE_LIMIT(3)) dut_b (
        .clock(clock), .reset(reset), .request_valid(req_valid[1]), .request_ready(req_ready[1]),
        .request_source_mac(src[1]), .request_destination_mac(dst[1]), .request_source_port(sport[1]),
        .response_valid(resp_valid[1]), .response_ready(resp_ready[1]), .response_port_mask(mask[1]),
        .response_hit(hit[1]), .flush(flush[1]), .entry_count(cnt_b));

    mac_learning_table #(.NUMBER_OF_PORTS(4), .TABLE_ENTRIES(4), .AGE_TICK_CYCLES(20), .AGE_LIMIT(50)) dut_c (
        .clock(clock), .reset(reset), .request_valid(req_valid[2]), .request_ready(req_ready[2]),
        .request_source_mac(src[2]), .request_destination_mac(dst[2]), .request_source_port(sport[2]),
        .response_valid(resp_valid[2]), .response_ready(resp_ready[2]), .response_port_mask(mask[2]),
        .response_hit(hit[2]), .flush(flush[2]), .entry_count(cnt_c));

    // Issues one request and waits for its response; lat counts cycles from the accept cycle
    task automatic lookup(input int d, input logic [47:0] s, input logic [47:0] t, input logic [1:0] p,
                          output logic [3:0] m, output logic h, output int lat);
        int w;
        w = 0; m = '0; h = 1'b0; lat = -1;
        while (!req_ready[d] && w < 100) begin @(negedge clock); w++; end
        if (!req_ready[d]) begin
            total++;
            $display("FAIL lookup_ready dut%0d: request_ready=0 after %0d cycles, want 1", d, w);
            return;
        end
        req_valid[d] = 1'b1; src[d] = s; dst[d] = t; sport[d] = p;
        @(negedge clock);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 200) begin @(negedge clock); lat++; end
        if (!resp_valid[d]) begin
            total++;
            $display("FAIL lookup_response dut%0d: response_valid=0 after %0d cycles, want 1", d, lat);
            lat = -1;
            return;
        end
        m = mask[d]; h = hit[d];
        if (resp_ready[d]) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++; if (req_ready[0] !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready[0]); else passed++;
        total++; if (resp_valid[0] !== 1'b0) $display("FAIL reset_valid: got %b want 0", resp_valid[0]); else passed++;
        total++; if (mask[0] !== 4'b0000 || hit[0] !== 1'b0) $display("FAIL reset_fields: mask %b hit %b want 0000/0", mask[0], hit[0]); else passed++;
        total++; if (cnt_a !== 5'd0) $display("FAIL reset_count: got %0d want 0", cnt_a); else passed++;
        reset = 1'b0;
        @(negedge clock);
        total++; if (req_ready[0] !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready[0]); else passed++;
    endtask

    task automatic test_learn_forward();
        logic [3:0] m; logic h; int lat;
        lookup(0, M1, BCAST, 2'd2, m, h, lat);
        total++; if (m !== 4'b1011 || h !== 1'b0) $display("FAIL learn_bcast: mask %b hit %b want 1011/0", m, h); else passed++;
        total++; if (cnt_a !== 5'd1) $display("FAIL learn_count1: got %0d want 1", cnt_a); else passed++;
        lookup(0, M2, M1, 2'd0, m, h, lat);
        total++; if (m !== 4'b0100 || h !== 1'b1) $display("FAIL forward_hit: mask %b hit %b want 0100/1", m, h); else passed++;
        total++; if (lat !== 18) $display("FAIL forward_latency: got %0d want 18", lat); else passed++;
        total++; if (cnt_a !== 5'd2) $display("FAIL learn_count2: got %0d want 2", cnt_a); else passed++;
    endtask

    task automatic test_unknown_filter();
        logic [3:0] m; logic h; int lat;
        lookup(0, M3, MUNK, 2'd1, m, h, lat);
        total++; if (m !== 4'b1101 || h !== 1'b0) $display("FAIL unknown_flood: mask %b hit %b want 1101/0", m, h); else passed++;
        lookup(0, M4, M1, 2'd2, m, h, lat);
        total++; if (m !== 4'b0000 || h !== 1'b1) $display("FAIL filter_same_port: mask %b hit %b want 0000/1", m, h); else passed++;
        lookup(0, M5, M5, 2'd3, m, h, lat);
        total++; if (m !== 4'b0111 || h !== 1'b0) $display("FAIL self_first_sight: mask %b hit %b want 0111/0", m, h); else passed++;
        total++; if (cnt_a !== 5'd5) $display("FAIL unknown_count: got %0d want 5", cnt_a); else passed++;
    endtask

    task automatic test_full_replace();
        logic [3:0] m; logic h; int lat;
        lookup(2, M1, BCAST, 2'd0, m, h, lat); repeat (25) @(negedge clock);
        lookup(2, M2, BCAST, 2'd1, m, h, lat); repeat (25) @(negedge clock);
        lookup(2, M3, BCAST, 2'd2, m, h, lat); repeat (25) @(negedge clock);
        lookup(2, M4, BCAST, 2'd0, m, h, lat); repeat (25) @(negedge clock);
        total++; if (cnt_c !== 3'd4) $display("FAIL full_count_before: got %0d want 4", cnt_c); else passed++;
        lookup(2, M5, BCAST, 2'd1, m, h, lat);
        total++; if (cnt_c !== 3'd4) $display("FAIL full_count_after: got %0d want 4", cnt_c); else passed++;
        lookup(2, MMC, M1, 2'd3, m, h, lat);
        total++; if (m !== 4'b0111 || h !== 1'b0) $display("FAIL replaced_oldest_miss: mask %b hit %b want 0111/0", m, h); else passed++;
        lookup(2, MMC, M5, 2'd3, m, h, lat);
        total++; if (m !== 4'b0010 || h !== 1'b1) $display("FAIL replacement_hit: mask %b hit %b want 0010/1", m, h); else passed++;
        total++; if (cnt_c !== 3'd4) $display("FAIL multicast_src_no_learn: got %0d want 4", cnt_c); else passed++;
    endtask

    task automatic test_aging();
        logic [3:0] m; logic h; int lat;
        lookup(1, M1, BCAST, 2'd1, m, h, lat);
        total++; if (cnt_b !== 3'd1) $display("FAIL aging_count_learn: got %0d want 1", cnt_b); else passed++;
        repeat (35) @(negedge clock);
        total++; if (cnt_b !== 3'd0) $display("FAIL aging_count_expired: got %0d want 0", cnt_b); else passed++;
        lookup(1, M2, M1, 2'd0, m, h, lat);
        total++; if (m !== 4'b1110 || h !== 1'b0) $display("FAIL aging_flood: mask %b hit %b want 1110/0", m, h); else passed++;
    endtask

    task automatic test_flush_mid_scan();
        int w;
        w = 0;
        while (!req_ready[0] && w < 100) begin @(negedge clock); w++; end
        req_valid[0] = 1'b1; src[0] = M2; dst[0] = M1; sport[0] = 2'd3;
        @(negedge clock);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clock);
        flush[0] = 1'b1;
        @(negedge clock);
        flush[0] = 1'b0;
        w = 0;
        while (!resp_valid[0] && w < 100) begin @(negedge clock); w++; end
        total++; if (mask[0] !== 4'b0100 || hit[0] !== 1'b1) $display("FAIL flush_scan_response: mask %b hit %b want 0100/1", mask[0], hit[0]); else passed++;
        @(negedge clock);
        total++; if (req_ready[0] !== 1'b0) $display("FAIL flush_ready_low: got %b want 0", req_ready[0]); else passed++;
        @(negedge clock);
        total++; if (req_ready[0] !== 1'b1) $display("FAIL flush_ready_back: got %b want 1", req_ready[0]); else passed++;
        total++; if (cnt_a !== 5'd0) $display("FAIL flush_count: got %0d want 0", cnt_a); else passed++;
    endtask

    task automatic test_backpressure_reset();
        int w;
        bit seen;
        resp_ready[0] = 1'b0;
        w = 0;
        while (!req_ready[0] && w < 100) begin @(negedge clock); w++; end
        req_valid[0] = 1'b1; src[0] = M1; dst[0] = BCAST; sport[0] = 2'd2;
        @(negedge clock);
        req_valid[0] = 1'b0;
        w = 0;
        while (!resp_valid[0] && w < 100) begin @(negedge clock); w++; end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (resp_valid[0] !== 1'b1 || mask[0] !== 4'b1011 || hit[0] !== 1'b0)
                $display("FAIL backpressure_hold%0d: valid %b mask %b hit %b want 1/1011/0", i, resp_valid[0], mask[0], hit[0]);
            else passed++;
            @(negedge clock);
        end
        resp_ready[0] = 1'b1;
        @(negedge clock);
        total++; if (resp_valid[0] !== 1'b0) $display("FAIL backpressure_release: valid %b want 0", resp_valid[0]); else passed++;
        total++; if (cnt_a !== 5'd1) $display("FAIL backpressure_count: got %0d want 1", cnt_a); else passed++;
        req_valid[0] = 1'b1; src[0] = M2; dst[0] = M1; sport[0] = 2'd0;
        @(negedge clock);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++; if (resp_valid[0] !== 1'b0 || cnt_a !== 5'd0) $display("FAIL reset_mid_scan: valid %b count %0d want 0/0", resp_valid[0], cnt_a); else passed++;
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (resp_valid[0]) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL reset_no_response: response seen %b want 0", seen); else passed++;
    endtask

    initial begin
        for (int i = 0; i < ND; i++) begin
            req_valid[i] = 1'b0; src[i] = '0; dst[i] = '0; sport[i] = '0;
            resp_ready[i] = 1'b1; flush[i] = 1'b0;
        end
        test_reset();
        test_learn_forward();
        test_unknown_filter();
        test_full_replace();
        test_aging();
        test_flush_mid_scan();
        test_backpressure_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
